// File: rtl/apb_protocol.sv
// APB subsystem: one IDLE/SETUP/ACCESS master plus two zero-wait 64x8 memory slaves.
// Address bit 8 picks the slave; offsets with addr[7:6] != 0 raise the slave error.
module apb_protocol (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       transfer,
    input  logic       READ_WRITE,
    input  logic [8:0] apb_write_paddr,
    input  logic [7:0] apb_write_data,
    input  logic [8:0] apb_read_paddr,
    output logic       PSLVERR,
    output logic [7:0] apb_read_data_out
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned IDX_W  = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                pwrite_q;
    logic                psel_q;
    logic                penable_q;
    logic                pslverr_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [DATA_W-1:0]   mem1_q [DEPTH];
    logic [DATA_W-1:0]   mem2_q [DEPTH];

    logic [ADDR_W-1:0]   req_addr_c;
    logic                start_c;
    logic                pready_c;
    logic                psel1_c;
    logic                psel2_c;
    logic                offset_ok_c;
    logic [IDX_W-1:0]    idx_c;
    logic                slverr_c;
    logic [DATA_W-1:0]   prdata_c;
    logic                wr1_c;
    logic                wr2_c;

    // A new transfer is launched from IDLE or straight out of a completing ACCESS.
    assign req_addr_c  = READ_WRITE ? apb_read_paddr : apb_write_paddr;
    assign start_c     = transfer && (state_q == IDLE || state_q == ACCESS);
    assign pready_c    = (state_q == ACCESS);

    assign psel1_c     = psel_q & ~paddr_q[8];
    assign psel2_c     = psel_q &  paddr_q[8];
    assign offset_ok_c = (paddr_q[7:6] == 2'b00);
    assign idx_c       = paddr_q[IDX_W-1:0];
    assign slverr_c    = psel_q & penable_q & ~offset_ok_c;

    // Slave read mux; invalid offsets and unselected slaves return zero.
    always_comb begin
        prdata_c = '0;
        if (offset_ok_c) begin
            if (psel1_c) begin
                prdata_c = mem1_q[idx_c];
            end else if (psel2_c) begin
                prdata_c = mem2_q[idx_c];
            end
        end
    end

    // Writes are gated by PRESETn so a reset at the ACCESS edge aborts them.
    assign wr1_c = PRESETn & psel1_c & penable_q & pwrite_q & offset_ok_c;
    assign wr2_c = PRESETn & psel2_c & penable_q & pwrite_q & offset_ok_c;

    always_ff @(posedge PCLK) begin
        if (wr1_c) begin
            mem1_q[idx_c] <= pwdata_q;
        end
        if (wr2_c) begin
            mem2_q[idx_c] <= pwdata_q;
        end
    end

    // Master FSM with registered bus controls and completion outputs.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pslverr_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    if (transfer) begin
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_c) begin
                        pslverr_q <= slverr_c;
                        if (!pwrite_q) begin
                            rdata_q <= prdata_c;
                        end
                        penable_q <= 1'b0;
                        if (transfer) begin
                            state_q <= SETUP;
                        end else begin
                            state_q <= IDLE;
                            psel_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
            if (start_c) begin
                paddr_q  <= req_addr_c;
                pwrite_q <= ~READ_WRITE;
                pwdata_q <= apb_write_data;
                psel_q   <= 1'b1;
            end
        end
    end

    assign PSLVERR           = pslverr_q;
    assign apb_read_data_out = rdata_q;

endmodule

// File: tb/tb_apb_protocol.sv
// Directed bench for apb_protocol: back-to-back transfer sequences with per-transfer expected results.
module tb_apb_protocol;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       transfer = 1'b0;
    logic       READ_WRITE = 1'b0;
    logic [8:0] apb_write_paddr = '0;
    logic [7:0] apb_write_data = '0;
    logic [8:0] apb_read_paddr = '0;
    logic       PSLVERR;
    logic [7:0] apb_read_data_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit         rw;
        logic [8:0] a;
        logic [7:0] d;
        bit         err;
        logic [7:0] rd;
    } op_t;

    op_t ops[$];

    apb_protocol dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .PSLVERR           (PSLVERR),
        .apb_read_data_out (apb_read_data_out)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit rw, input logic [8:0] a, input logic [7:0] d,
                        input bit err, input logic [7:0] rd);
        op_t o;
        o.rw = rw; o.a = a; o.d = d; o.err = err; o.rd = rd;
        ops.push_back(o);
    endtask

    task automatic check_op(input int k);
        check_eq($sformatf("err[%0d] %s a=%03h", k, ops[k].rw ? "rd" : "wr", ops[k].a),
                 32'(PSLVERR), 32'(ops[k].err));
        check_eq($sformatf("data[%0d] %s a=%03h", k, ops[k].rw ? "rd" : "wr", ops[k].a),
                 32'(apb_read_data_out), 32'(ops[k].rd));
    endtask

    // Runs the queued ops back-to-back, disturbing every input while the transfer is in flight.
    task automatic run_ops();
        for (int i = 0; i < ops.size(); i++) begin
            READ_WRITE      = ops[i].rw;
            apb_write_paddr = ops[i].rw ? ~ops[i].a : ops[i].a;
            apb_read_paddr  = ops[i].rw ? ops[i].a : ~ops[i].a;
            apb_write_data  = ops[i].d;
            transfer        = 1'b1;
            @(posedge PCLK); #1;
            if (i > 0) check_op(i - 1);
            check_eq($sformatf("setup[%0d] state", i), 32'(dut.state_q), 32'd1);
            transfer        = 1'b0;
            READ_WRITE      = ~ops[i].rw;
            apb_write_paddr = ~apb_write_paddr;
            apb_read_paddr  = ~apb_read_paddr;
            apb_write_data  = ~ops[i].d;
            @(posedge PCLK); #1;
        end
        @(posedge PCLK); #1;
        check_op(ops.size() - 1);
        ops.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " state"},   32'(dut.state_q),   32'd0);
        check_eq({tag, " psel"},    32'(dut.psel_q),    32'd0);
        check_eq({tag, " penable"}, 32'(dut.penable_q), 32'd0);
        check_eq({tag, " paddr"},   32'(dut.paddr_q),   32'd0);
        check_eq({tag, " pslverr"}, 32'(PSLVERR),       32'd0);
        check_eq({tag, " rdata"},   32'(apb_read_data_out), 32'd0);
    endtask

    initial begin
        int active;
        repeat (2) @(posedge PCLK);
        #1;
        check_reset_state("reset");
        PRESETn = 1'b1;

        // Unwritten location reads zero.
        push(1'b1, 9'd45, 8'h00, 1'b0, 8'h00);
        run_ops();

        for (int i = 0; i < 8; i++) push(1'b0, 9'(i), 8'(2 * i), 1'b0, 8'h00);
        run_ops();

        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        check_reset_state("pulse");
        PRESETn = 1'b1;

        for (int i = 0; i < 8; i++) push(1'b1, 9'(i), 8'h00, 1'b0, 8'(2 * i));
        run_ops();

        push(1'b0, 9'h105, 8'hAA, 1'b0, 8'h0E);
        push(1'b0, 9'h005, 8'h11, 1'b0, 8'h0E);
        push(1'b1, 9'h105, 8'h00, 1'b0, 8'hAA);
        push(1'b1, 9'h005, 8'h00, 1'b0, 8'h11);
        run_ops();

        push(1'b0, 9'd100, 8'h77, 1'b1, 8'h11);
        push(1'b1, 9'd36,  8'h00, 1'b0, 8'h00);
        push(1'b1, 9'd100, 8'h00, 1'b1, 8'h00);
        push(1'b1, 9'd3,   8'h00, 1'b0, 8'h06);
        run_ops();

        // Reset lands on the ACCESS edge of a write to location 3.
        READ_WRITE      = 1'b0;
        apb_write_paddr = 9'd3;
        apb_write_data  = 8'h5A;
        transfer        = 1'b1;
        @(posedge PCLK); #1;
        transfer = 1'b0;
        @(posedge PCLK); #1;
        check_eq("midrst access state", 32'(dut.state_q), 32'd2);
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        check_reset_state("midrst");
        PRESETn = 1'b1;

        push(1'b1, 9'd3, 8'h00, 1'b0, 8'h06);
        run_ops();

        active = 0;
        for (int c = 0; c < 12; c++) begin
            READ_WRITE      = 1'(c);
            apb_write_paddr = 9'(c * 37);
            apb_read_paddr  = 9'(c * 53);
            apb_write_data  = 8'(c * 19);
            @(posedge PCLK); #1;
            active += int'(dut.psel_q) + int'(dut.penable_q);
        end
        check_eq("idle bus activity", 32'(active), 32'd0);
        check_eq("idle state",  32'(dut.state_q), 32'd0);
        check_eq("idle rdata",  32'(apb_read_data_out), 32'h06);
        check_eq("idle pslverr", 32'(PSLVERR), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
